icache_data_ctrl: RTL



---
 rtl/icache_pkg.sv | 20 ++
 rtl/icache_data_ctrl_if.sv | 29 ++
 rtl/icache_data_ctrl.sv | 138 +++++++++++++
 3 files changed

// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - shared constants and state type for the icache data SRAM controller
package icache_pkg;

   localparam int ICACHE_SETS      = 64;
   localparam int ICACHE_IDX_BITS  = $clog2(ICACHE_SETS);
   localparam int ICACHE_LINE_BITS = 128;
   localparam int FILL_BEAT_BITS   = 64;
   localparam int FILL_BEATS       = ICACHE_LINE_BITS / FILL_BEAT_BITS;
   localparam int ICACHE_WMASKS    = ICACHE_LINE_BITS / 8;

   localparam logic [ICACHE_WMASKS-1:0] BEAT0_WMASK = 16'h00FF;
   localparam logic [ICACHE_WMASKS-1:0] BEAT1_WMASK = 16'hFF00;

   typedef enum logic [1:0] {
      ST_INIT,
      ST_IDLE,
      ST_FILL
   } ctrl_state_e;

endpackage

// File: rtl/icache_data_ctrl_if.sv
// rtl/icache_data_ctrl_if.sv - fetch read, response and line-fill handshakes of the icache data controller
interface icache_data_ctrl_if #(
   parameter int ADDR_WIDTH = icache_pkg::ICACHE_IDX_BITS,
   parameter int DATA_WIDTH = icache_pkg::ICACHE_LINE_BITS,
   parameter int BEAT_WIDTH = icache_pkg::FILL_BEAT_BITS
);

   logic                  rd_valid;
   logic                  rd_ready;
   logic [ADDR_WIDTH-1:0] rd_idx;
   logic                  rsp_valid;
   logic [DATA_WIDTH-1:0] rsp_data;
   logic                  fill_valid;
   logic                  fill_ready;
   logic [ADDR_WIDTH-1:0] fill_idx;
   logic [BEAT_WIDTH-1:0] fill_data;
   logic                  fill_done;

   modport master (
      output rd_valid, rd_idx, fill_valid, fill_idx, fill_data,
      input  rd_ready, rsp_valid, rsp_data, fill_ready, fill_done
   );

   modport slave (
      input  rd_valid, rd_idx, fill_valid, fill_idx, fill_data,
      output rd_ready, rsp_valid, rsp_data, fill_ready, fill_done
   );

endinterface

// File: rtl/icache_data_ctrl.sv
// rtl/icache_data_ctrl.sv - owns the icache data SRAM RW port: zeroing sweep, line fills, fetch reads
module icache_data_ctrl
   import icache_pkg::*;
#(
   parameter int ADDR_WIDTH = ICACHE_IDX_BITS,
   parameter int DATA_WIDTH = ICACHE_LINE_BITS,
   parameter int BEAT_WIDTH = FILL_BEAT_BITS,
   parameter int NUM_WMASKS = DATA_WIDTH / 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   icache_data_ctrl_if.slave     bus,
   output logic                  init_done,
   output logic                  csb0,
   output logic                  web0,
   output logic [NUM_WMASKS-1:0] wmask0,
   output logic [ADDR_WIDTH-1:0] addr0,
   output logic [DATA_WIDTH-1:0] din0,
   input  logic [DATA_WIDTH-1:0] dout0
);

   localparam int BEATS          = DATA_WIDTH / BEAT_WIDTH;
   localparam int BYTES_PER_BEAT = BEAT_WIDTH / 8;
   localparam int BEAT_CNT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;

   localparam logic [ADDR_WIDTH-1:0] LAST_IDX       = '1;
   localparam logic [BEAT_CNT_W-1:0] LAST_BEAT      = BEAT_CNT_W'(BEATS - 1);
   localparam logic [NUM_WMASKS-1:0] BEAT_BASE_MASK = NUM_WMASKS'({BYTES_PER_BEAT{1'b1}});

   ctrl_state_e           state_q, state_d;
   logic [ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d;
   logic [BEAT_CNT_W-1:0] beat_q, beat_d;
   logic [ADDR_WIDTH-1:0] line_idx_q, line_idx_d;
   logic                  init_done_q, init_done_d;
   logic                  rsp_valid_q, rd_accept;
   logic                  fill_done_q, fill_last;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_INIT;
         init_cnt_q  <= '0;
         beat_q      <= '0;
         line_idx_q  <= '0;
         init_done_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         fill_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         init_cnt_q  <= init_cnt_d;
         beat_q      <= beat_d;
         line_idx_q  <= line_idx_d;
         init_done_q <= init_done_d;
         rsp_valid_q <= rd_accept;
         fill_done_q <= fill_last;
      end
   end

   always_comb begin
      state_d        = state_q;
      init_cnt_d     = init_cnt_q;
      beat_d         = beat_q;
      line_idx_d     = line_idx_q;
      init_done_d    = init_done_q;
      rd_accept      = 1'b0;
      fill_last      = 1'b0;
      csb0           = 1'b1;
      web0           = 1'b1;
      wmask0         = '0;
      addr0          = '0;
      din0           = '0;
      bus.rd_ready   = 1'b0;
      bus.fill_ready = 1'b0;

      // Held in reset the macro port must stay idle even though state_q may not be cleared yet.
      if (rst_n) begin
         case (state_q)
            ST_INIT: begin
               csb0       = 1'b0;
               web0       = 1'b0;
               wmask0     = '1;
               addr0      = init_cnt_q;
               init_cnt_d = init_cnt_q + 1'b1;
               if (init_cnt_q == LAST_IDX) begin
                  state_d     = ST_IDLE;
                  init_done_d = 1'b1;
               end
            end
            ST_IDLE: begin
               bus.fill_ready = 1'b1;
               bus.rd_ready   = !bus.fill_valid;
               if (bus.fill_valid) begin
                  csb0       = 1'b0;
                  web0       = 1'b0;
                  addr0      = bus.fill_idx;
                  din0       = {BEATS{bus.fill_data}};
                  wmask0     = BEAT_BASE_MASK;
                  line_idx_d = bus.fill_idx;
                  if (BEATS == 1) begin
                     fill_last = 1'b1;
                  end else begin
                     beat_d  = BEAT_CNT_W'(1);
                     state_d = ST_FILL;
                  end
               end else if (bus.rd_valid) begin
                  csb0      = 1'b0;
                  addr0     = bus.rd_idx;
                  rd_accept = 1'b1;
               end
            end
            ST_FILL: begin
               // Reads stay blocked until the whole line is written.
               bus.fill_ready = 1'b1;
               if (bus.fill_valid) begin
                  csb0   = 1'b0;
                  web0   = 1'b0;
                  addr0  = line_idx_q;
                  din0   = {BEATS{bus.fill_data}};
                  wmask0 = BEAT_BASE_MASK << (32'(beat_q) * BYTES_PER_BEAT);
                  if (beat_q == LAST_BEAT) begin
                     beat_d    = '0;
                     state_d   = ST_IDLE;
                     fill_last = 1'b1;
                  end else begin
                     beat_d = beat_q + 1'b1;
                  end
               end
            end
            default: state_d = ST_INIT;
         endcase
      end
   end

   assign bus.rsp_valid = rsp_valid_q & rst_n;
   assign bus.rsp_data  = dout0;
   assign bus.fill_done = fill_done_q & rst_n;
   assign init_done     = init_done_q & rst_n;

endmodule
